// File: rtl/dyn_partition_pkg.sv
// Shared types and the transition relation of the two-partition dynamic counter.
// The downstream checker model calls next_state for the default width.
package dyn_partition_pkg;

  localparam int unsigned W_PKG = 3;

  typedef struct packed {
    logic             p1;
    logic             p0;
    logic [W_PKG-1:0] b;
    logic [W_PKG-1:0] a;
  } dp_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_t;

  // The mode bit selects which partition counts. The phase walks the Johnson
  // sequence 00->01->11->10 as {p1,p0}.
  function automatic dp_state_t next_state(input dp_state_t s);
    dp_state_t n;
    n = s;
    if (s.p0 ^ s.p1) n.b = s.b + W_PKG'(1);
    else             n.a = s.a + W_PKG'(1);
    n.p0 = ~s.p1;
    n.p1 = s.p0;
    return n;
  endfunction

endpackage

// File: rtl/dyn_partition_next.sv
// Combinational successor f(S) on the packed state {p1,p0,B,A}.
module dyn_partition_next #(
  parameter int unsigned W = 3
) (
  input  logic [2*W+1:0] cur,
  output logic [2*W+1:0] nxt
);

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         p0;
  logic         p1;

  always_comb begin
    a   = cur[W-1:0];
    b   = cur[2*W-1:W];
    p0  = cur[2*W];
    p1  = cur[2*W+1];
    nxt = cur;
    if (p0 ^ p1) nxt[2*W-1:W] = b + W'(1);
    else         nxt[W-1:0]   = a + W'(1);
    nxt[2*W]   = ~p1;
    nxt[2*W+1] = p0;
  end

endmodule

// File: rtl/dyn_partition_stepper.sv
// Steps the dynamic-counter state from a seed, one state per accepted beat,
// until the trajectory returns to the seed, the step budget runs out, or abort.
module dyn_partition_stepper
  import dyn_partition_pkg::*;
#(
  parameter  int unsigned W         = 3,
  parameter  int unsigned MAX_STEPS = 64,
  localparam int unsigned CW        = $clog2(MAX_STEPS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2*W+1:0]  seed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W+1:0]  out_cur,
  output logic [2*W+1:0]  out_nxt,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [CW-1:0]   cycle_len
);

  localparam int unsigned SW = 2 * W + 2;

  fsm_t          state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [SW-1:0] seed_q, seed_d;
  logic [CW-1:0] step_q, step_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          found_q, found_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [SW-1:0] s_nxt;
  logic          fire;
  logic [CW-1:0] step_inc;

  dyn_partition_next #(.W(W)) u_next (
    .cur (s_q),
    .nxt (s_nxt)
  );

  assign fire     = valid_q & out_ready;
  assign step_inc = step_q + CW'(1);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    seed_d  = seed_q;
    step_d  = step_q;
    cyc_d   = cyc_q;
    found_d = found_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = seed;
          seed_d  = seed;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          s_d    = s_nxt;
          step_d = step_inc;
        end
        // Closure outranks the budget; abort only decides when no beat ends the run.
        if (fire && s_nxt == seed_q) begin
          state_d = ST_DONE;
          found_d = 1'b1;
          cyc_d   = step_inc;
        end else if (fire && step_inc == CW'(MAX_STEPS)) begin
          state_d = ST_DONE;
          found_d = 1'b0;
          cyc_d   = CW'(MAX_STEPS);
        end else if (abort) begin
          state_d = ST_DONE;
          found_d = 1'b0;
          cyc_d   = step_q + CW'(fire);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      seed_q  <= '0;
      step_q  <= '0;
      cyc_q   <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      seed_q  <= seed_d;
      step_q  <= step_d;
      cyc_q   <= cyc_d;
      found_q <= found_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_cur   = s_q;
  assign out_nxt   = s_nxt;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign cycle_len = cyc_q;

endmodule

// File: tb/tb_dyn_partition_stepper.sv
// Randomized bench for dyn_partition_stepper against a phase-index reference model.
module tb_dyn_partition_stepper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [7:0] seed = '0;
  logic       out_valid, busy, done, found;
  logic [7:0] out_cur, out_nxt;
  logic [6:0] cycle_len;

  logic       start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic [7:0] seed_b = '0;
  logic       valid_b, busy_b, done_b, found_b;
  logic [7:0] cur_b, nxt_b;
  logic [3:0] cycle_len_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dyn_partition_stepper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_cur(out_cur), .out_nxt(out_nxt),
    .busy(busy), .done(done), .found(found), .cycle_len(cycle_len)
  );

  dyn_partition_stepper #(.W(3), .MAX_STEPS(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .seed(seed_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_cur(cur_b), .out_nxt(nxt_b),
    .busy(busy_b), .done(done_b), .found(found_b), .cycle_len(cycle_len_b)
  );

  // Reference: phase as an index 0..3 into the Johnson order; odd phases count B.
  function automatic logic [7:0] m_next(input logic [7:0] s);
    int a, b, ph;
    logic [1:0] pb;
    a  = int'(s[2:0]);
    b  = int'(s[5:3]);
    pb = {s[7], s[6]};
    case (pb)
      2'b00:   ph = 0;
      2'b01:   ph = 1;
      2'b11:   ph = 2;
      default: ph = 3;
    endcase
    if (ph % 2 == 0) a = (a + 1) % 8;
    else             b = (b + 1) % 8;
    ph = (ph + 1) % 4;
    case (ph)
      0:       pb = 2'b00;
      1:       pb = 2'b01;
      2:       pb = 2'b11;
      default: pb = 2'b10;
    endcase
    return {pb, 3'(b), 3'(a)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; seed = 8'h2D;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || cycle_len !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b b=%b d=%b f=%b len=%0d exp all 0", out_valid, busy, done, found, cycle_len);
    end
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got v=%b b=%b exp 0 0", out_valid, busy);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready pattern 0,0,1
  task automatic test_cycle(input logic [7:0] sd, input int mode);
    logic [7:0] cur;
    int n, k;
    bit running, rdy;
    @(negedge clk); seed = sd; start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0; seed = 8'($urandom);
    cur = sd; n = 0; k = 0; running = 1'b1;
    while (running && k < 1000) begin
      checks++;
      if (out_valid !== 1'b1 || out_cur !== cur || out_nxt !== m_next(cur)) begin
        failures++;
        $display("FAIL beat%0d got v=%b cur=%h nxt=%h exp v=1 cur=%h nxt=%h", n + 1, out_valid, out_cur, out_nxt, cur, m_next(cur));
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k % 3 == 2);
      out_ready = rdy;
      if (rdy) begin
        cur = m_next(cur); n++;
        if (cur == sd) begin
          running = 1'b0;
          checks++;
          if (out_nxt !== sd) begin
            failures++;
            $display("FAIL final_nxt got=%h exp=%h", out_nxt, sd);
          end
        end else if (n == 64) running = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || found !== (cur == sd) || cycle_len !== 7'(n) || n != 16) begin
      failures++;
      $display("FAIL run_end got d=%b b=%b v=%b f=%b len=%0d exp d=1 b=1 v=0 f=1 len=16 (model %0d)", done, busy, out_valid, found, cycle_len, n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || found !== 1'b1 || cycle_len !== 7'd16) begin
      failures++;
      $display("FAIL done_pulse got d=%b b=%b f=%b len=%0d exp d=0 b=0 f=1 len=16", done, busy, found, cycle_len);
    end
  endtask

  task automatic test_backpressure();
    test_cycle(8'h2D, 2);
  endtask

  task automatic test_budget(input logic [7:0] sd);
    logic [7:0] cur;
    int n;
    @(negedge clk); seed_b = sd; start_b = 1'b1; ready_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cur = sd;
    for (n = 0; n < 10; n++) begin
      checks++;
      if (valid_b !== 1'b1 || cur_b !== cur) begin
        failures++;
        $display("FAIL budget_beat%0d got v=%b cur=%h exp v=1 cur=%h", n + 1, valid_b, cur_b, cur);
      end
      cur = m_next(cur);
      @(negedge clk);
    end
    ready_b = 1'b0;
    checks++;
    if (done_b !== 1'b1 || found_b !== 1'b0 || cycle_len_b !== 4'd10) begin
      failures++;
      $display("FAIL budget_end got d=%b f=%b len=%0d exp d=1 f=0 len=10", done_b, found_b, cycle_len_b);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [7:0] cur;
    @(negedge clk); seed = 8'h00; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    cur = 8'h00;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (out_valid !== 1'b1 || out_cur !== cur) begin
        failures++;
        $display("FAIL abort_beat%0d got v=%b cur=%h exp v=1 cur=%h", n + 1, out_valid, out_cur, cur);
      end
      start = (n == 1);
      abort = (n == 4);
      cur = m_next(cur);
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b1; out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || found !== 1'b0 || cycle_len !== 7'd5) begin
      failures++;
      $display("FAIL abort_end got d=%b f=%b len=%0d exp d=1 f=0 len=5", done, found, cycle_len);
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || cycle_len !== 7'd5 || found !== 1'b0) begin
      failures++;
      $display("FAIL start_while_busy got v=%b b=%b len=%0d f=%b exp v=0 b=0 len=5 f=0", out_valid, busy, cycle_len, found);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); seed = 8'h00; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got v=%b b=%b exp 0 0", out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cycle_len !== 7'd0) begin
      failures++;
      $display("FAIL reset_no_done got d=%b len=%0d exp d=0 len=0", done, cycle_len);
    end
    rst_n = 1'b1; out_ready = 1'b0;
    test_cycle(8'h00, 0);
  endtask

  initial begin
    test_reset();
    test_cycle(8'h00, 0);
    for (int i = 0; i < 3; i++) test_cycle(8'($urandom), 1);
    test_backpressure();
    test_budget(8'h00);
    test_budget(8'($urandom));
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
